// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, reset PC, major opcodes and
// instruction field positions. Imported by the fetch unit, control unit and decoder.
package riscv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned INST_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Instruction field slice positions
  localparam int unsigned OP_LSB  = 0;
  localparam int unsigned OP_MSB  = 6;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned F3_MSB  = 14;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS1_MSB = 19;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RS2_MSB = 24;
  localparam int unsigned F7_LSB  = 25;
  localparam int unsigned F7_MSB  = 31;

  // True for opcodes that can change control flow once resolved downstream.
  function automatic logic is_ctrl_flow(input logic [6:0] op);
    return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Response buffer for the fetch unit: DEPTH-entry FIFO carrying {pc, inst} pairs.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   flush                  synchronous clear, wins over push/pop
//   push, push_pc/inst     write one entry (dropped if full and not popping)
//   pop                    consume head (ignored when empty)
//   empty, count           occupancy status
//   head_pc, head_inst     current head entry (undefined when empty)
module fetch_fifo #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [31:0]     push_inst,
  input  logic            pop,
  output logic            empty,
  output logic [CntW-1:0] count,
  output logic [XLEN-1:0] head_pc,
  output logic [31:0]     head_inst
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            full, push_en, pop_en;

  // Wrapping increment that also works for non-power-of-two depths.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  always_comb begin
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop_en)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  // Payload storage needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (push_en && !flush) begin
      pc_mem[wr_ptr_q]   <= push_pc;
      inst_mem[wr_ptr_q] <= push_inst;
    end
  end

  assign count     = count_q;
  assign head_pc   = pc_mem[rd_ptr_q];
  assign head_inst = inst_mem[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end. Holds the PC, issues in-order word fetches under a
// credit limit of DEPTH, buffers responses and presents them to decode with the
// opcode/funct fields pre-sliced. A redirect reloads the PC, flushes the buffer and
// arranges for every still-outstanding response to be discarded.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   imem_req_valid/ready/addr       fetch request channel (word-aligned address)
//   imem_rsp_valid/data             in-order fetch responses
//   redirect_valid/pc               taken branch/jump target from execute
//   dec_ready                       decode accepts the presented instruction
//   inst_valid, inst, inst_pc       instruction presented to decode
//   Op, funct3, funct7              fields of inst
module instr_fetch_unit #(
  parameter int unsigned      XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(riscv_pkg::RESET_PC),
  parameter int unsigned      DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            dec_ready,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      Op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7
);

  import riscv_pkg::*;

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic            run_q;

  // Request-address tags, one per outstanding request, consumed in response order.
  logic [XLEN-1:0] tag_mem [DEPTH];
  logic [PtrW-1:0] tag_wr_q, tag_rd_q;

  logic            fifo_empty, fifo_push, fifo_pop;
  logic [CntW-1:0] fifo_count;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_inst;

  logic [CntW:0]   credit_used;
  logic            req_fire, rsp_drop;
  logic            unused_redirect_lsb;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Buffered plus outstanding words may never exceed the buffer size, so every
  // response always has a slot waiting for it.
  assign credit_used    = {1'b0, inflight_q} + {1'b0, fifo_count};
  // run_q keeps the request line low while in reset and for the first cycle after.
  assign imem_req_valid = run_q && !redirect_valid && (credit_used < (CntW + 1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_q != '0);

  assign fifo_push = imem_rsp_valid && !rsp_drop && !redirect_valid;
  assign fifo_pop  = inst_valid && dec_ready;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (req_fire) begin
      pc_d       = pc_q + XLEN'(4);
      inflight_d = inflight_q + CntW'(1);
    end
    if (imem_rsp_valid) begin
      inflight_d = inflight_d - CntW'(1);
      if (rsp_drop) drop_d = drop_q - CntW'(1);
    end
    if (redirect_valid) begin
      pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
      // No request fires this cycle, so inflight_d already excludes a same-cycle
      // response; everything still outstanding belongs to the old path.
      drop_d = inflight_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      run_q      <= 1'b0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      run_q      <= 1'b1;
      if (req_fire)       tag_wr_q <= ptr_inc(tag_wr_q);
      if (imem_rsp_valid) tag_rd_q <= ptr_inc(tag_rd_q);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr_q] <= pc_q;
  end

  fetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_pc   (tag_mem[tag_rd_q]),
    .push_inst (imem_rsp_data),
    .pop       (fifo_pop),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_pc   (head_pc),
    .head_inst (head_inst)
  );

  // Zero the outputs when nothing is presented so reset and idle read as all-zero.
  assign inst_valid = !fifo_empty;
  assign inst       = inst_valid ? head_inst : '0;
  assign inst_pc    = inst_valid ? head_pc : '0;
  assign Op         = inst[OP_MSB:OP_LSB];
  assign funct3     = inst[F3_MSB:F3_LSB];
  assign funct7     = inst[F7_MSB:F7_LSB];

  assign unused_redirect_lsb = ^redirect_pc[1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic [6:0]  Op, funct7;
  logic [2:0]  funct3;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .Op             (Op),
    .funct3         (funct3),
    .funct7         (funct7)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: outstanding accepted addresses and the cycle each may answer.
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0;
  int          lat = 1;

  // Program-order reference: next PC to request and next PC decode should see.
  logic [31:0] exp_req_pc, exp_pc;
  int          n_consumed = 0;
  int          n_accepts  = 0;
  logic [31:0] last_pc, last_acc;
  logic        stalled_prev = 1'b0;
  logic [31:0] stalled_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic timeout(input string tag, input int budget);
    n_checks++;
    n_fail++;
    $error("FAIL %s: no completion within %0d cycles", tag, budget);
  endtask

  // One clock cycle; entered and left just after a falling edge.
  task automatic tick();
    logic        acc, cons, rsp, redir;
    logic [31:0] w, a, ipc, tgt;
    #1;
    acc   = imem_req_valid && imem_req_ready;
    cons  = inst_valid && dec_ready;
    rsp   = imem_rsp_valid;
    redir = redirect_valid;
    a     = imem_req_addr;
    ipc   = inst_pc;
    tgt   = {redirect_pc[31:2], 2'b00};
    if (redir) check("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
    if (acc) begin
      check("req_addr", a, exp_req_pc);
      check("credit_ok", 32'(mq_addr.size() < DEPTH), 32'd1);
    end
    if (stalled_prev) begin
      check("stall_valid", 32'(inst_valid), 32'd1);
      check("stall_pc", ipc, stalled_pc);
    end
    if (cons) begin
      w = mem_word(exp_pc);
      check("inst_pc", ipc, exp_pc);
      check("inst", inst, w);
      check("op", 32'(Op), 32'(w[6:0]));
      check("funct3", 32'(funct3), 32'(w[14:12]));
      check("funct7", 32'(funct7), 32'(w[31:25]));
    end
    stalled_prev = inst_valid && !dec_ready && !redir;
    stalled_pc   = ipc;
    @(posedge clk);
    cyc++;
    if (rsp) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (acc) begin
      mq_addr.push_back(a);
      mq_due.push_back(cyc + lat - 1);
      exp_req_pc = exp_req_pc + 32'd4;
      n_accepts++;
      last_acc = a;
    end
    if (cons) begin
      exp_pc = exp_pc + 32'd4;
      n_consumed++;
      last_pc = ipc;
    end
    if (redir) begin
      exp_req_pc = tgt;
      exp_pc     = tgt;
    end
    @(negedge clk);
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // Asserts reset part-way through a cycle and checks the outputs drop at once.
  task automatic apply_reset();
    #2;
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    dec_ready      = 1'b1;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_op", 32'(Op), 32'd0);
    check("rst_funct3", 32'(funct3), 32'd0);
    check("rst_funct7", 32'(funct7), 32'd0);
    mq_addr.delete();
    mq_due.delete();
    exp_req_pc   = RESET_PC;
    exp_pc       = RESET_PC;
    stalled_prev = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_consumed(input int n, input int budget, input string tag);
    int target = n_consumed + n;
    for (int i = 0; i < budget && n_consumed < target; i++) tick();
    if (n_consumed < target) timeout(tag, budget);
  endtask

  task automatic wait_first_consumed(input string tag, input logic [31:0] expv, input int budget);
    int base = n_consumed;
    for (int i = 0; i < budget && n_consumed == base; i++) tick();
    if (n_consumed == base) timeout(tag, budget);
    else check(tag, last_pc, expv);
  endtask

  task automatic wait_first_accept(input string tag, input logic [31:0] expv, input int budget);
    int base = n_accepts;
    for (int i = 0; i < budget && n_accepts == base; i++) tick();
    if (n_accepts == base) timeout(tag, budget);
    else check(tag, last_acc, expv);
  endtask

  initial begin
    int  base;
    bit  found;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b1;
    exp_req_pc     = RESET_PC;
    exp_pc         = RESET_PC;

    // 1: streaming from reset with a 1-cycle memory
    apply_reset();
    lat = 1;
    wait_first_accept("p1_first_req", RESET_PC, 10);
    run_consumed(10, 60, "p1_stream");

    // 2: decode stalled from reset; only DEPTH requests may be issued
    apply_reset();
    dec_ready = 1'b0;
    base = n_accepts;
    repeat (10) tick();
    check("p2_stall_accepts", 32'(n_accepts - base), 32'(DEPTH));
    check("p2_head_valid", 32'(inst_valid), 32'd1);
    check("p2_head_pc", inst_pc, RESET_PC);
    dec_ready = 1'b1;
    run_consumed(4, 30, "p2_release");

    // 3: redirect with PCs 8 and C outstanding
    apply_reset();
    lat = 4;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (mq_addr.size() == 2 && mq_addr[0] == 32'h8 && mq_addr[1] == 32'hC) found = 1'b1;
    end
    if (!found) timeout("p3_setup", 60);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    wait_first_consumed("p3_first_pc", 32'h100, 40);
    run_consumed(3, 40, "p3_after");

    // 4: unaligned redirect in the same cycle as a response
    lat = 1;
    for (int i = 0; i < 20 && !imem_rsp_valid; i++) tick();
    if (!imem_rsp_valid) timeout("p4_setup", 20);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
    wait_first_accept("p4_req_addr", 32'h100, 20);
    wait_first_consumed("p4_first_pc", 32'h100, 20);
    run_consumed(3, 30, "p4_after");

    // 5: random memory backpressure, 3-cycle memory
    lat  = 3;
    base = n_consumed;
    for (int i = 0; i < 200; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("p5_progress", 32'((n_consumed - base) >= 20), 32'd1);

    // 5b: random stalls and redirects on top
    for (int i = 0; i < 300; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      dec_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom;
      tick();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;

    // 5c: address wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF9;
    tick();
    redirect_valid = 1'b0;
    wait_first_consumed("wrap_first_pc", 32'hFFFF_FFF8, 30);
    run_consumed(3, 30, "wrap_run");
    check("wrap_pc", last_pc, 32'h4);

    // 6: reset in the middle of a burst
    for (int i = 0; i < 7; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      tick();
    end
    imem_req_ready = 1'b1;
    apply_reset();
    wait_first_accept("p6_first_req", RESET_PC, 20);
    run_consumed(4, 40, "p6_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
